mem_io: RTL and testbench
=========================

MEM_IO -- requirements
Module: mem_io

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 8, meaning the RAM address width (2^RAM_AW words of 16 bits).
REQ-002 The block SHALL have parameter TX_DEPTH, default 4, meaning the TX FIFO depth in entries (power of 2, at least 2).
REQ-003 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-005 Port addr: input, 16 bits, word address from the processor.
REQ-006 Port wdata: input, 16 bits, write data from the processor.
REQ-007 Port we: input, 1 bit, write enable from the processor.
REQ-008 Port rdata: output, 16 bits, read data to the processor din.
REQ-009 Port tx_data: output, 8 bits, head byte of the TX FIFO.
REQ-010 Port tx_valid: output, 1 bit, TX FIFO non-empty.
REQ-011 Port tx_ready: input, 1 bit, the consumer accepts the head byte.
REQ-012 Port rx_data: input, 8 bits, incoming byte.
REQ-013 Port rx_valid: input, 1 bit, one-cycle strobe qualifying rx_data.

Function
REQ-014 The memory map SHALL be: 0x0000..2^RAM_AW-1 RAM; 0xFF00 TXDATA; 0xFF01 STATUS; 0xFF02 RXDATA; 0xFF03 TIMER; all other addresses unmapped.
REQ-015 Reads SHALL be combinational from addr and current state, with no read side effects, so the processor may hold addr for any number of cycles.
REQ-016 RAM writes SHALL occur on the clk edge when we=1 and addr is in the RAM range; RAM contents are not reset.
REQ-017 A read of an unmapped address or TXDATA SHALL return 0x0000, and a write to an unmapped address SHALL be ignored.
REQ-018 A write to TXDATA SHALL push wdata[7:0] into the TX FIFO.
  - If the FIFO is full with no pop in the same cycle, the byte is dropped and tx_ovf is set.
REQ-019 A TX FIFO pop SHALL occur on each edge where tx_valid=1 and tx_ready=1, and tx_data SHALL present the head entry.
REQ-020 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full (no overflow) and when it holds one entry.
REQ-021 A push into an empty FIFO SHALL raise tx_valid on the following cycle (1-cycle latency).
REQ-022 FIFO read/write pointers SHALL wrap modulo TX_DEPTH, and full/empty SHALL be distinguished by an extra pointer bit or a count.
REQ-023 STATUS read SHALL return {11'b0, rx_ovf, tx_ovf, rx_full, tx_full, tx_empty} in bits [15:0].
REQ-024 Any write to STATUS SHALL clear tx_ovf and rx_ovf.
  - An overflow event in the same cycle wins, and the flag stays 1.
REQ-025 When rx_valid=1 and rx_full=0, the block SHALL capture rx_data and set rx_full.
  - When rx_full=1, the byte is dropped and rx_ovf is set.
REQ-026 RXDATA read SHALL return {8'h00, rx_byte}.
REQ-027 A write to RXDATA SHALL clear rx_full.
  - If rx_valid=1 in the same cycle, the new byte is captured and rx_full stays 1 with no overflow.
REQ-028 TIMER SHALL increment by 1 every cycle and wrap 0xFFFF->0x0000.
  - A write loads wdata on that edge, without increment that cycle.
REQ-029 TIMER read SHALL return the current count.

Reset
REQ-030 On reset assertion, the block SHALL immediately force:
  - TX FIFO empty; tx_valid=0; tx_data=0x00.
  - rx_full, rx_ovf, tx_ovf = 0; rx_byte=0x00; TIMER=0x0000.
REQ-031 Reset asserted mid-transfer SHALL discard FIFO contents without a pop handshake, while RAM contents are retained.
REQ-032 After deassertion, TIMER SHALL read 0x0001 after the first clk edge.

Verification
REQ-033 Write 0xBEEF to 0x0010, then read 0x0010 -> rdata=0xBEEF; read 0x0100 (unmapped, RAM_AW=8) -> 0x0000.
REQ-034 With tx_ready=0, write 0x41,0x42,0x43,0x44,0x45 to 0xFF00 -> STATUS=0x000A (tx_full, tx_ovf); then set tx_ready=1 -> tx_data sequence 0x41..0x44, then tx_valid=0 and STATUS=0x0009.
REQ-035 With the FIFO full, write 0x55 to TXDATA while tx_ready=1 -> no overflow and the FIFO stays full, with 0x55 as the last entry.
REQ-036 Pulse rx_valid with 0x5A, then with 0x33 -> RXDATA=0x005A and STATUS bits rx_full=1, rx_ovf=1; write STATUS -> rx_ovf=0; write RXDATA in the same cycle as rx_valid with 0x77 -> rx_full=1 and RXDATA=0x0077.
REQ-037 Write 0xFFFE to TIMER -> reads 0xFFFE, 0xFFFF, 0x0000 on successive cycles.
REQ-038 Assert reset asynchronously between edges with 3 bytes queued -> tx_valid=0 immediately; RAM word 0x0010 still reads 0xBEEF.

Source files
------------

// File: rtl/mem_io.sv
// Memory-mapped I/O block: word RAM, TX byte FIFO, single-byte RX holding register
// and a free-running 16-bit timer, all addressable over one processor port.
module mem_io #(
  parameter int unsigned RAM_AW   = 8,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  output logic [15:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int unsigned PW        = $clog2(TX_DEPTH);
  localparam int unsigned RAM_WORDS = 2 ** RAM_AW;

  localparam logic [15:0] ADDR_TXDATA = 16'hFF00;
  localparam logic [15:0] ADDR_STATUS = 16'hFF01;
  localparam logic [15:0] ADDR_RXDATA = 16'hFF02;
  localparam logic [15:0] ADDR_TIMER  = 16'hFF03;

  logic [15:0] ram [RAM_WORDS];
  logic [7:0]  tx_mem [TX_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        tx_ovf, rx_ovf, rx_full;
  logic [7:0]  rx_byte;
  logic [15:0] timer;

  logic in_ram, tx_empty, tx_full;
  logic tx_push_req, tx_push, tx_pop;
  logic status_wr, rx_clr, timer_wr;

  // Address decode and handshake qualification
  assign in_ram      = 32'(addr) < RAM_WORDS;
  assign tx_push_req = we && (addr == ADDR_TXDATA);
  assign status_wr   = we && (addr == ADDR_STATUS);
  assign rx_clr      = we && (addr == ADDR_RXDATA);
  assign timer_wr    = we && (addr == ADDR_TIMER);

  // Extra pointer MSB separates full from empty when the index bits match
  assign tx_empty = (wr_ptr == rd_ptr);
  assign tx_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[rd_ptr[PW-1:0]];
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = tx_push_req && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (we && in_ram) ram[addr[RAM_AW-1:0]] <= wdata;
  end

  // When full with a simultaneous pop, this overwrites the slot being read out this cycle
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[wr_ptr[PW-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      if (tx_push_req && tx_full && !tx_pop) tx_ovf <= 1'b1;
      else if (status_wr)                    tx_ovf <= 1'b0;
    end
  end

  // RX holding register; a same-cycle clear frees the slot for the incoming byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_full <= 1'b0;
      rx_ovf  <= 1'b0;
      rx_byte <= 8'h00;
    end else begin
      if (rx_valid && (!rx_full || rx_clr)) begin
        rx_byte <= rx_data;
        rx_full <= 1'b1;
      end else if (rx_clr) begin
        rx_full <= 1'b0;
      end
      if (rx_valid && rx_full && !rx_clr) rx_ovf <= 1'b1;
      else if (status_wr)                 rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         timer <= 16'h0000;
    else if (timer_wr) timer <= wdata;
    else               timer <= timer + 16'h0001;
  end

  // Side-effect-free combinational read mux
  always_comb begin
    rdata = 16'h0000;
    if (in_ram) begin
      rdata = ram[addr[RAM_AW-1:0]];
    end else begin
      case (addr)
        ADDR_STATUS: rdata = {11'b0, rx_ovf, tx_ovf, rx_full, tx_full, tx_empty};
        ADDR_RXDATA: rdata = {8'h00, rx_byte};
        ADDR_TIMER:  rdata = timer;
        default:     rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io.sv
// Directed bench for mem_io: RAM, TX FIFO, RX register, timer and async reset.
module tb_mem_io;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr, wdata, rdata;
  logic        we;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int n_cmp = 0;
  int n_err = 0;

  mem_io #(.RAM_AW(8), .TX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // One write transaction spanning a single rising edge
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; addr = 16'hFF03; wdata = '0; we = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    #12;
    chk("rst_tx_valid", 16'(tx_valid), 16'h0000);
    chk("rst_tx_data", 16'(tx_data), 16'h0000);
    rd("rst_status", 16'hFF01, 16'h0001);
    rd("rst_timer", 16'hFF03, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd("timer_first_edge", 16'hFF03, 16'h0001);

    // RAM and unmapped space
    wr(16'h0010, 16'hBEEF);
    rd("ram_0010", 16'h0010, 16'hBEEF);
    rd("unmapped_0100", 16'h0100, 16'h0000);
    rd("txdata_read", 16'hFF00, 16'h0000);

    // Fill FIFO past capacity
    for (int i = 0; i < 5; i++) wr(16'hFF00, 16'(8'h41 + i));
    rd("status_full_ovf", 16'hFF01, 16'h000A);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 16'(tx_valid), 16'h0001);
      chk("drain_data", 16'(tx_data), 16'(8'h41 + i));
      @(negedge clk);
    end
    chk("drained_valid", 16'(tx_valid), 16'h0000);
    tx_ready = 1'b0;
    rd("status_empty_ovf", 16'hFF01, 16'h0009);
    wr(16'hFF01, 16'h0000);
    rd("status_ovf_clr", 16'hFF01, 16'h0001);

    // Push while full with a same-cycle pop
    for (int i = 0; i < 4; i++) wr(16'hFF00, 16'(8'h61 + i));
    rd("status_full", 16'hFF01, 16'h0002);
    @(negedge clk);
    addr = 16'hFF00; wdata = 16'h0055; we = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    we = 1'b0; tx_ready = 1'b0;
    rd("status_full_no_ovf", 16'hFF01, 16'h0002);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain2_data", 16'(tx_data), (i == 3) ? 16'h0055 : 16'(8'h62 + i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("drain2_empty", 16'(tx_valid), 16'h0000);

    // RX register, overflow, clear and same-cycle recapture
    @(negedge clk); rx_data = 8'h5A; rx_valid = 1'b1;
    @(negedge clk); rx_data = 8'h33;
    @(negedge clk); rx_valid = 1'b0;
    rd("rxdata_first", 16'hFF02, 16'h005A);
    rd("status_rx_ovf", 16'hFF01, 16'h0015);
    wr(16'hFF01, 16'h0000);
    rd("status_rx_ovf_clr", 16'hFF01, 16'h0005);
    @(negedge clk);
    addr = 16'hFF02; we = 1'b1; rx_data = 8'h77; rx_valid = 1'b1;
    @(negedge clk);
    we = 1'b0; rx_valid = 1'b0;
    rd("rxdata_recapture", 16'hFF02, 16'h0077);
    rd("status_recapture", 16'hFF01, 16'h0005);
    wr(16'hFF02, 16'h0000);
    rd("status_rx_clr", 16'hFF01, 16'h0001);

    // Timer load and wrap
    wr(16'hFF03, 16'hFFFE);
    rd("timer_load", 16'hFF03, 16'hFFFE);
    @(negedge clk);
    rd("timer_ffff", 16'hFF03, 16'hFFFF);
    @(negedge clk);
    rd("timer_wrap", 16'hFF03, 16'h0000);

    // Async reset with bytes queued
    for (int i = 0; i < 3; i++) wr(16'hFF00, 16'(8'hA0 + i));
    chk("queued_valid", 16'(tx_valid), 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 16'(tx_valid), 16'h0000);
    chk("async_rst_data", 16'(tx_data), 16'h0000);
    rd("async_rst_status", 16'hFF01, 16'h0001);
    rd("async_rst_timer", 16'hFF03, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    rd("ram_retained", 16'h0010, 16'hBEEF);
    @(negedge clk);
    chk("post_rst_valid", 16'(tx_valid), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
